// File: rtl/csa16_adder.sv
// Registered carry-select adder: {cout,s} = a + b + cin, one cycle latency.
// Define CSA16_ADDER_CHECK_EN to add a ripple-carry reference and a registered mismatch flag.
module csa16_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLK_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef CSA16_ADDER_CHECK_EN
    output logic             mismatch,
`endif
    output logic             out_valid
);

    localparam int unsigned NBLK = WIDTH / BLK_W;

    function automatic logic [BLK_W:0] rca(
        input logic [BLK_W-1:0] x,
        input logic [BLK_W-1:0] y,
        input logic             c
    );
        logic [BLK_W-1:0] sum;
        logic             c_r;
        c_r = c;
        sum = '0;
        for (int unsigned i = 0; i < BLK_W; i++) begin
            sum[i] = x[i] ^ y[i] ^ c_r;
            c_r    = (x[i] & y[i]) | (c_r & (x[i] ^ y[i]));
        end
        return {c_r, sum};
    endfunction

    logic [NBLK:0]    w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        if (g == 0) begin : g_first
            assign {w_carry[1], w_sum[BLK_W-1:0]} =
                rca(a[BLK_W-1:0], b[BLK_W-1:0], w_carry[0]);
        end else begin : g_sel
            logic [BLK_W:0] w_r0;
            logic [BLK_W:0] w_r1;
            assign w_r0 = rca(a[g*BLK_W +: BLK_W], b[g*BLK_W +: BLK_W], 1'b0);
            assign w_r1 = rca(a[g*BLK_W +: BLK_W], b[g*BLK_W +: BLK_W], 1'b1);
            // Both speculative results are ready; the incoming block carry only steers the mux.
            assign {w_carry[g+1], w_sum[g*BLK_W +: BLK_W]} = w_carry[g] ? w_r1 : w_r0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= w_sum;
                cout <= w_carry[NBLK];
            end
        end
    end

`ifdef CSA16_ADDER_CHECK_EN
    logic [WIDTH-1:0] w_ref_sum;
    logic             w_ref_cout;

    always_comb begin
        logic c_r;
        c_r       = cin;
        w_ref_sum = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_ref_sum[i] = a[i] ^ b[i] ^ c_r;
            c_r          = (a[i] & b[i]) | (c_r & (a[i] ^ b[i]));
        end
        w_ref_cout = c_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else begin
            mismatch <= in_valid &&
                        ({w_ref_cout, w_ref_sum} != {w_carry[NBLK], w_sum});
        end
    end
`endif

endmodule

// File: tb/tb_csa16_adder.sv
// Directed checks for csa16_adder: reset, vectors, hold, back-to-back, mid-stream reset.
module tb_csa16_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        out_valid;
`ifdef CSA16_ADDER_CHECK_EN
    logic        mismatch;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    csa16_adder #(.WIDTH(16), .BLK_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
`ifdef CSA16_ADDER_CHECK_EN
        .mismatch  (mismatch),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One valid sample, then check the registered result right after the edge.
    task automatic apply(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic [15:0] es, input logic ec);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".s"}, {16'h0, s}, {16'h0, es});
        check({tag, ".cout"}, {31'h0, cout}, {31'h0, ec});
        check({tag, ".vld"}, {31'h0, out_valid}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [16:0] exp17;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2;
        check("rst.s", {16'h0, s}, 32'h0);
        check("rst.cout", {31'h0, cout}, 32'h0);
        check("rst.vld", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle.vld", {31'h0, out_valid}, 32'h0);
        check("idle.s", {16'h0, s}, 32'h0);

        apply("v1", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0);
        apply("v2", 16'hAB32, 16'h2121, 1'b0, 16'hCC53, 1'b0);
        apply("v3", 16'hF800, 16'hFAAA, 1'b0, 16'hF2AA, 1'b1);
        apply("v4", 16'h0800, 16'hDAAA, 1'b0, 16'hE2AA, 1'b0);
        apply("v5", 16'h0000, 16'h0003, 1'b0, 16'h0003, 1'b0);
        apply("v6", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        apply("v7", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        apply("v8", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        apply("v9", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);

        // Hold: in_valid low with changed operands keeps the last result.
        a = 16'h1111; b = 16'h2222; cin = 1'b1;
        @(posedge clk);
        #1;
        check("hold.vld", {31'h0, out_valid}, 32'h0);
        check("hold.s", {16'h0, s}, 32'h1000);
        check("hold.cout", {31'h0, cout}, 32'h0);

        // Back-to-back valids.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b0.s", {16'h0, s}, 32'h0002);
        check("b2b0.vld", {31'h0, out_valid}, 32'h1);
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
        @(posedge clk);
        #1;
        check("b2b1.s", {16'h0, s}, 32'h8000);
        check("b2b1.vld", {31'h0, out_valid}, 32'h1);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(posedge clk);
        #1;
        check("b2b2.s", {16'h0, s}, 32'hFFFF);
        check("b2b2.cout", {31'h0, cout}, 32'h1);

        // Mid-stream reset with in_valid still high: clears without a clock edge.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("mrst.s", {16'h0, s}, 32'h0);
        check("mrst.cout", {31'h0, cout}, 32'h0);
        check("mrst.vld", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("mrst.edge.s", {16'h0, s}, 32'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post.vld", {31'h0, out_valid}, 32'h0);
        check("post.s", {16'h0, s}, 32'h0);

        // Random vectors against the bench's own 17-bit sum.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            in_valid = 1'b1;
            exp17 = {1'b0, a} + {1'b0, b} + {16'h0, cin};
            @(posedge clk);
            #1;
            check("rnd.sum", {15'h0, cout, s}, {15'h0, exp17});
`ifdef CSA16_ADDER_CHECK_EN
            check("rnd.mismatch", {31'h0, mismatch}, 32'h0);
`endif
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("end.vld", {31'h0, out_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
